// File: rtl/led_event_generator.sv
// led_event_generator: turns raw board activity pulses and status levels into
// per-LED mode/start/stop commands for the LED processor, one channel per LED.
module led_event_generator #(
    parameter int LED_NUM         = 4,
    parameter int SYSCLK_RATE     = 100,
    parameter int HOLDOFF_MS      = 100,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LED_NUM-1:0]      cfg_kind,
    input  logic [LED_NUM-1:0]      event_in,
    input  logic [LED_NUM-1:0]      level_in,
    output logic [LED_NUM-1:0][7:0] mode,
    output logic [LED_NUM-1:0]      start,
    output logic [LED_NUM-1:0]      stop,
    output logic [LED_NUM-1:0]      busy
);

    localparam int HOLD_CYCLES = HOLDOFF_MS * SYSCLK_RATE * 1000;
    localparam int HOLD_W      = $clog2(HOLD_CYCLES + 1);
    localparam int DEB_W       = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_ZERO  = DEB_W'(0);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [LED_NUM-1:0]      ev_s1_q, ev_s1_d;
    logic [LED_NUM-1:0]      ev_s2_q, ev_s2_d;
    logic [LED_NUM-1:0]      ev_h_q,  ev_h_d;
    logic [LED_NUM-1:0]      lv_s1_q, lv_s1_d;
    logic [LED_NUM-1:0]      lv_s2_q, lv_s2_d;
    logic [LED_NUM-1:0]      ev_rise_s;

    logic [LED_NUM-1:0]      kind_q,  kind_d;
    logic [LED_NUM-1:0]      state_q, state_d;
    logic [LED_NUM-1:0]      pend_q,  pend_d;
    logic [LED_NUM-1:0]      deb_q,   deb_d;
    logic [HOLD_W-1:0]       hold_q [LED_NUM];
    logic [HOLD_W-1:0]       hold_d [LED_NUM];
    logic [DEB_W-1:0]        dcnt_q [LED_NUM];
    logic [DEB_W-1:0]        dcnt_d [LED_NUM];

    logic [LED_NUM-1:0]      start_q, start_d;
    logic [LED_NUM-1:0]      stop_q,  stop_d;
    logic [LED_NUM-1:0]      busy_q,  busy_d;
    logic [LED_NUM-1:0][7:0] mode_q,  mode_d;

    // Synchroniser chain and activity edge detect
    always_comb begin
        ev_s1_d   = event_in;
        ev_s2_d   = ev_s1_q;
        ev_h_d    = ev_s2_q;
        lv_s1_d   = level_in;
        lv_s2_d   = lv_s1_q;
        ev_rise_s = ev_s2_q & ~ev_h_q;
    end

    // Per-channel next-state: kind change, activity holdoff FSM, level debounce
    always_comb begin
        for (int i = 0; i < LED_NUM; i++) begin
            kind_d[i]  = kind_q[i];
            state_d[i] = state_q[i];
            pend_d[i]  = pend_q[i];
            deb_d[i]   = deb_q[i];
            hold_d[i]  = hold_q[i];
            dcnt_d[i]  = dcnt_q[i];
            start_d[i] = 1'b0;
            stop_d[i]  = 1'b0;

            if (cfg_kind[i] != kind_q[i]) begin
                // Abort whatever was running; the old kind is still on mode this cycle
                kind_d[i]  = cfg_kind[i];
                stop_d[i]  = busy_q[i];
                state_d[i] = ST_IDLE;
                pend_d[i]  = 1'b0;
                deb_d[i]   = 1'b0;
                hold_d[i]  = HOLD_ZERO;
                dcnt_d[i]  = DEB_ZERO;
            end else if (kind_q[i] == 1'b0) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (ev_rise_s[i]) begin
                            start_d[i] = 1'b1;
                            hold_d[i]  = HOLD_LOAD;
                            state_d[i] = ST_HOLD;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                        if (hold_q[i] == HOLD_ZERO) begin
                            // Only reached with a request pending: reissue and re-arm
                            start_d[i] = 1'b1;
                            hold_d[i]  = HOLD_LOAD;
                            pend_d[i]  = ev_rise_s[i];
                        end else if (hold_q[i] == HOLD_ONE) begin
                            hold_d[i] = HOLD_ZERO;
                            if (pend_q[i] || ev_rise_s[i]) begin
                                pend_d[i] = 1'b1;
                            end else begin
                                state_d[i] = ST_IDLE;
                            end
                        end else begin
                            hold_d[i] = hold_q[i] - HOLD_ONE;
                            if (ev_rise_s[i]) begin
                                pend_d[i] = 1'b1;
                            end else begin
                                pend_d[i] = pend_q[i];
                            end
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        hold_d[i]  = HOLD_ZERO;
                        pend_d[i]  = 1'b0;
                    end
                endcase
            end else begin
                if (lv_s2_q[i] != deb_q[i]) begin
                    if (dcnt_q[i] == DEB_LAST) begin
                        deb_d[i]   = ~deb_q[i];
                        dcnt_d[i]  = DEB_ZERO;
                        start_d[i] = ~deb_q[i];
                        stop_d[i]  = deb_q[i];
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DEB_ONE;
                    end
                end else begin
                    dcnt_d[i] = DEB_ZERO;
                end
            end

            if (kind_d[i]) begin
                busy_d[i] = deb_d[i];
            end else begin
                busy_d[i] = (state_d[i] == ST_HOLD);
            end
            mode_d[i] = {7'b0000000, kind_q[i]};
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ev_s1_q <= '0;
            ev_s2_q <= '0;
            ev_h_q  <= '0;
            lv_s1_q <= '0;
            lv_s2_q <= '0;
            kind_q  <= '0;
            state_q <= '0;
            pend_q  <= '0;
            deb_q   <= '0;
            start_q <= '0;
            stop_q  <= '0;
            busy_q  <= '0;
            mode_q  <= '0;
            for (int i = 0; i < LED_NUM; i++) begin
                hold_q[i] <= HOLD_ZERO;
                dcnt_q[i] <= DEB_ZERO;
            end
        end else begin
            ev_s1_q <= ev_s1_d;
            ev_s2_q <= ev_s2_d;
            ev_h_q  <= ev_h_d;
            lv_s1_q <= lv_s1_d;
            lv_s2_q <= lv_s2_d;
            kind_q  <= kind_d;
            state_q <= state_d;
            pend_q  <= pend_d;
            deb_q   <= deb_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            busy_q  <= busy_d;
            mode_q  <= mode_d;
            for (int i = 0; i < LED_NUM; i++) begin
                hold_q[i] <= hold_d[i];
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    assign start = start_q;
    assign stop  = stop_q;
    assign busy  = busy_q;
    assign mode  = mode_q;

endmodule
